ps2_atom_keyboard: RTL and testbench

- Upstream of the PIA in the Atom top level. Replaces the tied-high keyboard, shift_n, ctrl_n and rept_n stubs.
- Receives PS/2 keyboard frames and decodes make/break scancodes into a 10-row x 6-column Atom key matrix.
- Returns the 6 active-low column bits for the row the CPU selects via PIA port A[3:0].

---
 rtl/ps2_atom_pkg.sv | 105 ++++++++++
 rtl/ps2_atom_keymap.sv | 22 ++
 rtl/ps2_atom_keyboard.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_atom_keyboard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_atom_pkg.sv
// Shared types and constants for the PS/2 to Acorn Atom keyboard bridge:
// receiver states, scancode prefixes, modifier codes and the key matrix map.
package ps2_atom_pkg;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  localparam logic [7:0] CodeE0 = 8'hE0;
  localparam logic [7:0] CodeF0 = 8'hF0;
  localparam logic [7:0] CodeE1 = 8'hE1;
  localparam logic [7:0] CodeAa = 8'hAA;
  localparam logic [7:0] CodeFa = 8'hFA;

  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;
  localparam logic [7:0] CodeCtrl   = 8'h14;
  localparam logic [7:0] CodeAlt    = 8'h11;

  localparam int unsigned NumRows = 10;
  localparam int unsigned NumCols = 6;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input logic [3:0] r, input logic [2:0] c);
    key_pos_t k;
    k.hit = 1'b1;
    k.row = r;
    k.col = c;
    return k;
  endfunction

  // Index is {ext, scancode}; anything not listed is a miss.
  function automatic key_pos_t keymap_lookup(input logic ext, input logic [7:0] code);
    key_pos_t k;
    k = '0;
    case ({ext, code})
      9'h023: k = kp(4'd0, 3'd4);  // D
      9'h021: k = kp(4'd1, 3'd4);  // C
      9'h032: k = kp(4'd2, 3'd4);  // B
      9'h01C: k = kp(4'd3, 3'd4);  // A
      9'h00E: k = kp(4'd4, 3'd4);  // @
      9'h05D: k = kp(4'd5, 3'd4);  // backslash
      9'h05B: k = kp(4'd6, 3'd4);  // ]
      9'h054: k = kp(4'd7, 3'd4);  // [
      9'h01A: k = kp(4'd8, 3'd4);  // Z
      9'h022: k = kp(4'd9, 3'd4);  // X
      9'h035: k = kp(4'd0, 3'd3);  // Y
      9'h01D: k = kp(4'd1, 3'd3);  // W
      9'h02A: k = kp(4'd2, 3'd3);  // V
      9'h03C: k = kp(4'd3, 3'd3);  // U
      9'h02C: k = kp(4'd4, 3'd3);  // T
      9'h175: k = kp(4'd5, 3'd3);  // Up
      9'h01B: k = kp(4'd6, 3'd3);  // S
      9'h02D: k = kp(4'd7, 3'd3);  // R
      9'h015: k = kp(4'd8, 3'd3);  // Q
      9'h04D: k = kp(4'd9, 3'd3);  // P
      9'h044: k = kp(4'd0, 3'd2);  // O
      9'h031: k = kp(4'd1, 3'd2);  // N
      9'h03A: k = kp(4'd2, 3'd2);  // M
      9'h04B: k = kp(4'd3, 3'd2);  // L
      9'h042: k = kp(4'd4, 3'd2);  // K
      9'h03B: k = kp(4'd5, 3'd2);  // J
      9'h043: k = kp(4'd6, 3'd2);  // I
      9'h033: k = kp(4'd7, 3'd2);  // H
      9'h034: k = kp(4'd8, 3'd2);  // G
      9'h02B: k = kp(4'd9, 3'd2);  // F
      9'h024: k = kp(4'd0, 3'd5);  // E
      9'h016: k = kp(4'd1, 3'd5);  // 1
      9'h01E: k = kp(4'd2, 3'd5);  // 2
      9'h026: k = kp(4'd3, 3'd5);  // 3
      9'h025: k = kp(4'd4, 3'd5);  // 4
      9'h02E: k = kp(4'd5, 3'd5);  // 5
      9'h036: k = kp(4'd6, 3'd5);  // 6
      9'h03D: k = kp(4'd7, 3'd5);  // 7
      9'h03E: k = kp(4'd8, 3'd5);  // 8
      9'h046: k = kp(4'd9, 3'd5);  // 9
      9'h045: k = kp(4'd0, 3'd1);  // 0
      9'h04E: k = kp(4'd1, 3'd1);  // -
      9'h055: k = kp(4'd2, 3'd1);  // =
      9'h04C: k = kp(4'd3, 3'd1);  // ;
      9'h041: k = kp(4'd4, 3'd1);  // ,
      9'h049: k = kp(4'd5, 3'd1);  // .
      9'h05A: k = kp(4'd6, 3'd1);  // Return
      9'h04A: k = kp(4'd7, 3'd1);  // /
      9'h066: k = kp(4'd8, 3'd1);  // Backspace -> DELETE
      9'h076: k = kp(4'd9, 3'd1);  // Esc
      9'h00D: k = kp(4'd0, 3'd0);  // Tab
      9'h16B: k = kp(4'd1, 3'd0);  // Left
      9'h174: k = kp(4'd2, 3'd0);  // Right
      9'h172: k = kp(4'd3, 3'd0);  // Down
      9'h058: k = kp(4'd4, 3'd0);  // Caps Lock
      9'h052: k = kp(4'd5, 3'd0);  // '
      9'h171: k = kp(4'd6, 3'd0);  // Delete
      9'h005: k = kp(4'd7, 3'd0);  // F1 -> COPY
      9'h169: k = kp(4'd8, 3'd0);  // End
      9'h029: k = kp(4'd9, 3'd0);  // Space
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_atom_keymap.sv
// Combinational scancode to Atom matrix position lookup.
module ps2_atom_keymap
  import ps2_atom_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] key_row,
  output logic [2:0] key_col
);

  key_pos_t pos;

  always_comb begin
    pos = keymap_lookup(ext, code);
  end

  assign hit     = pos.hit;
  assign key_row = pos.row;
  assign key_col = pos.col;

endmodule

// File: rtl/ps2_atom_keyboard.sv
// PS/2 keyboard receiver and scancode decoder producing the Atom 10x6 key
// matrix, the active-low column read for the PIA and the modifier lines.
module ps2_atom_keyboard
  import ps2_atom_pkg::*;
#(
  parameter int unsigned CLKSPEED       = 25000000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = CLKSPEED / 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] row,
  output logic [5:0] keyboard,
  output logic       shift_n,
  output logic       ctrl_n,
  output logic       rept_n,
  output logic       frame_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  // Input conditioning
  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             clk_filt_q, clk_filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fe;

  // Receiver
  rx_state_e       state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_byte_q;
  logic            frame_err_q, frame_err_d;

  // Decoder
  logic [NumRows-1:0][NumCols-1:0] matrix_q, matrix_d;
  logic       ext_q, ext_d, rel_q, rel_d;
  logic [2:0] skip_q, skip_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d, alt_q, alt_d;
  logic       hit;
  logic [3:0] key_row;
  logic [2:0] key_col;

  // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    fe         = 1'b0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s2_q;
        fe         = clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == StIdle || fe) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (fe) begin
      case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = dat_s2_q;
          state_d  = StStop;
        end
        StStop: begin
          if (dat_s2_q && (^{shift_q, parity_q})) begin
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
      tmo_d       = '0;
    end
  end

  ps2_atom_keymap u_keymap (
    .ext     (ext_q),
    .code    (rx_byte_q),
    .hit     (hit),
    .key_row (key_row),
    .key_col (key_col)
  );

  always_comb begin
    matrix_d = matrix_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    skip_d   = skip_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    ctrl_d   = ctrl_q;
    alt_d    = alt_q;
    if (rx_valid_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte_q)
          CodeE0: ext_d = 1'b1;
          CodeF0: rel_d = 1'b1;
          CodeE1: skip_d = 3'd7;
          CodeAa, CodeFa: begin
            matrix_d = '0;
            lshift_d = 1'b0;
            rshift_d = 1'b0;
            ctrl_d   = 1'b0;
            alt_d    = 1'b0;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
          end
          default: begin
            if (!ext_q && rx_byte_q == CodeLShift) begin
              lshift_d = !rel_q;
            end else if (!ext_q && rx_byte_q == CodeRShift) begin
              rshift_d = !rel_q;
            end else if (!ext_q && rx_byte_q == CodeCtrl) begin
              ctrl_d = !rel_q;
            end else if (!ext_q && rx_byte_q == CodeAlt) begin
              alt_d = !rel_q;
            end else if (hit && key_row < 4'(NumRows) && key_col < 3'(NumCols)) begin
              matrix_d[key_row][key_col] = !rel_q;
            end
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
      matrix_q    <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      rx_valid_q  <= rx_valid_d;
      if (rx_valid_d) begin
        rx_byte_q <= shift_q;
      end
      frame_err_q <= frame_err_d;
      matrix_q    <= matrix_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
    end
  end

  // Zero-latency read: the PIA samples port B in the same cycle it drives the row.
  always_comb begin
    keyboard = 6'h3F;
    if (row < 4'(NumRows)) begin
      keyboard = ~matrix_q[row];
    end
  end

  assign shift_n   = ~(lshift_q | rshift_q);
  assign ctrl_n    = ~ctrl_q;
  assign rept_n    = ~alt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_atom_keyboard.sv
// Scoreboard bench for ps2_atom_keyboard: stimulus queues expected matrix
// reads, a negedge monitor pops and compares them and tallies frame_err pulses.
module tb_ps2_atom_keyboard;

  localparam int unsigned Timeout = 1000;
  localparam int          Half    = 20;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] row      = 4'd0;
  logic [5:0] keyboard;
  logic       shift_n, ctrl_n, rept_n, frame_err;

  typedef struct {
    string      name;
    logic [5:0] kbd;
    logic [2:0] mods;
    int         errs;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         errors   = 0;
  int         err_seen = 0;
  logic [2:0] exp_mods = 3'b111;  // {shift_n, ctrl_n, rept_n}
  int         exp_errs = 0;

  ps2_atom_keyboard #(
    .CLKSPEED       (500000),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .row       (row),
    .keyboard  (keyboard),
    .shift_n   (shift_n),
    .ctrl_n    (ctrl_n),
    .rept_n    (rept_n),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (frame_err) err_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.name, " keyboard"}, int'(keyboard), int'(e.kbd));
      cmp({e.name, " modifiers"}, int'({shift_n, ctrl_n, rept_n}), int'(e.mods));
      cmp({e.name, " frame_err count"}, err_seen, e.errs);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [3:0] r, input logic [5:0] k);
    exp_t e;
    row    = r;
    e.name = $sformatf("%s row%0d", n, r);
    e.kbd  = k;
    e.mods = exp_mods;
    e.errs = exp_errs;
    sb.push_back(e);
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: monitor idle, got pending want consumed", n);
      sb.delete();
    end
  endtask

  // Every row 0..9 reads 3F except row r (r > 9 means none).
  task automatic chk_all(input string n, input logic [3:0] r, input logic [5:0] k);
    for (int i = 0; i < 10; i++) begin
      chk(n, 4'(i), (4'(i) == r) ? k : 6'h3F);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int nbits, input bit glitch);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(Half);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(Half);
      end
      ps2_clk = 1'b0;
      tick(Half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(3 * Half);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    exp_mods = 3'b111;
    tick(2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(5);
    reset_n = 1'b1;
    tick(50);

    chk_all("reset", 4'hF, 6'h3F);
    chk("reset", 4'hF, 6'h3F);

    send(8'h1C);
    chk_all("press A", 4'd3, 6'b101111);
    send(8'hF0); send(8'h1C);
    chk("release A", 4'd3, 6'h3F);

    send(8'h12); exp_mods = 3'b011; chk("lshift", 4'd0, 6'h3F);
    send(8'h59); chk("rshift", 4'd0, 6'h3F);
    send(8'hF0); send(8'h12); chk("lshift up", 4'd0, 6'h3F);
    send(8'hF0); send(8'h59); exp_mods = 3'b111; chk("rshift up", 4'd0, 6'h3F);
    send(8'hE0); send(8'h12); chk("fake shift", 4'd0, 6'h3F);
    send(8'h14); exp_mods = 3'b101; chk("ctrl", 4'd0, 6'h3F);
    send(8'h11); exp_mods = 3'b100; chk("alt", 4'd0, 6'h3F);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h11);
    exp_mods = 3'b111; chk("ctrl alt up", 4'd0, 6'h3F);

    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0); exp_errs = 1;
    chk("bad parity", 4'd3, 6'h3F);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0); exp_errs = 2;
    chk("bad stop", 4'd3, 6'h3F);
    send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
    tick(Timeout + 10); exp_errs = 3;
    chk("timeout", 4'd3, 6'h3F);
    send(8'h1C);
    chk("after timeout", 4'd3, 6'b101111);
    send(8'hF0); send(8'h1C);

    send(8'hE0); send(8'h75);
    chk_all("up", 4'd5, 6'b110111);
    send(8'h75);
    chk_all("keypad 8", 4'd5, 6'b110111);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up release", 4'd5, 6'h3F);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    chk_all("pause then A", 4'd3, 6'b101111);
    send(8'hF0); send(8'h1C);

    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b1);
    chk_all("glitch space", 4'd9, 6'b111110);
    send(8'hF0); send(8'h29);
    chk("space release", 4'd9, 6'h3F);

    send(8'h1C); send(8'h12); send(8'hE0); send(8'h75);
    exp_mods = 3'b011;
    chk("held A", 4'd3, 6'b101111);
    chk("held up", 4'd5, 6'b110111);
    pulse_reset();
    chk_all("after reset", 4'hF, 6'h3F);
    chk("after reset", 4'hF, 6'h3F);

    send_frame(8'h1C, 1'b0, 1'b1, 4, 1'b0);
    pulse_reset();
    tick(Timeout + 10);
    chk("reset mid frame", 4'd3, 6'h3F);

    send(8'h1C); send(8'h12); send(8'hE0); send(8'h75); send(8'h14); send(8'h11);
    exp_mods = 3'b000;
    chk("held again", 4'd3, 6'b101111);
    send(8'hAA);
    exp_mods = 3'b111;
    chk_all("BAT", 4'hF, 6'h3F);
    chk("BAT", 4'hF, 6'h3F);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
